// File: rtl/memory_request_queue_pkg.sv
// memory_request_queue_pkg: FSM state encoding and memory command constants
package memory_request_queue_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_t;
    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;
endpackage

// File: rtl/memory_request_queue_request_fifo.sv
// request_fifo: request storage with wrap-bit pointers, exposing the head entry
module request_fifo
    import memory_request_queue_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 3,
    parameter int QUEUE_DEPTH   = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [ADDRESS_WIDTH-1:0] i_push_addr,
    input  logic [DATA_WIDTH-1:0]    i_push_data,
    input  logic                     i_push_rw,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [ADDRESS_WIDTH-1:0] o_head_addr,
    output logic [DATA_WIDTH-1:0]    o_head_data,
    output logic                     o_head_rw
);
    localparam int IW = $clog2(QUEUE_DEPTH);

    logic [IW:0]              r_wr_ptr;
    logic [IW:0]              r_rd_ptr;
    logic [ADDRESS_WIDTH-1:0] r_addr [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0]    r_data [QUEUE_DEPTH];
    logic                     r_rw   [QUEUE_DEPTH];
    logic                     w_push;
    logic                     w_pop;

    assign o_full  = (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]) && (r_wr_ptr[IW] != r_rd_ptr[IW]);
    assign o_empty = r_wr_ptr == r_rd_ptr;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    assign o_head_addr = r_addr[r_rd_ptr[IW-1:0]];
    assign o_head_data = r_data[r_rd_ptr[IW-1:0]];
    assign o_head_rw   = r_rw[r_rd_ptr[IW-1:0]];

    // advance pointers; a push into a full queue is dropped even when a pop happens
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (IW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (IW+1)'(1);
        end
    end

    // write the accepted request into its slot
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr[IW-1:0]] <= i_push_addr;
            r_data[r_wr_ptr[IW-1:0]] <= i_push_data;
            r_rw[r_wr_ptr[IW-1:0]]   <= i_push_rw;
        end
    end
endmodule

// File: rtl/memory_request_queue.sv
// memory_request_queue: in-order request queue issuing one memory transaction at a time
module memory_request_queue
    import memory_request_queue_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 3,
    parameter int QUEUE_DEPTH   = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [ADDRESS_WIDTH-1:0] req_address_i,
    input  logic [DATA_WIDTH-1:0]    req_write_data_i,
    input  logic                     req_read_write_select_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    output logic [DATA_WIDTH-1:0]    resp_read_data_o,
    output logic                     resp_is_write_o,
    output logic                     resp_valid_o,
    output logic [ADDRESS_WIDTH-1:0] mem_address_o,
    output logic                     mem_address_valid_o,
    output logic [DATA_WIDTH-1:0]    mem_write_data_o,
    output logic                     mem_write_data_valid_o,
    output logic                     mem_read_write_select_o,
    input  logic [DATA_WIDTH-1:0]    mem_read_data_i,
    input  logic                     mem_read_data_valid_i,
    input  logic                     mem_write_done_i,
    input  logic                     mem_port_ready_i,
    output logic                     busy_o
);
    state_t                   r_state;
    state_t                   w_next;
    logic                     r_alive;
    logic                     r_inflight_write;
    logic [ADDRESS_WIDTH-1:0] r_last_addr;
    logic [DATA_WIDTH-1:0]    r_last_data;
    logic                     r_last_rw;
    logic [DATA_WIDTH-1:0]    r_resp_data;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_done;
    logic [ADDRESS_WIDTH-1:0] w_head_addr;
    logic [DATA_WIDTH-1:0]    w_head_data;
    logic                     w_head_rw;

    // r_alive keeps ready low until the first edge after reset releases
    assign req_ready_o      = r_alive && !w_full;
    assign w_push           = req_valid_i && req_ready_o;
    assign w_pop            = (r_state == ISSUE) && mem_port_ready_i;
    assign w_done           = mem_port_ready_i && (r_inflight_write == WRITE ? mem_write_done_i : mem_read_data_valid_i);
    assign resp_read_data_o = r_resp_data;
    assign busy_o           = !w_empty || (r_state != IDLE);

    request_fifo #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .QUEUE_DEPTH  (QUEUE_DEPTH)
    ) u_fifo (
        .i_clk      (clk_i),
        .i_rst      (reset_i),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_push_addr(req_address_i),
        .i_push_data(req_write_data_i),
        .i_push_rw  (req_read_write_select_i),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_head_addr(w_head_addr),
        .o_head_data(w_head_data),
        .o_head_rw  (w_head_rw)
    );

    // next state and outputs; mem_* fields replay the last issued entry outside ISSUE
    always_comb begin
        w_next                  = r_state;
        mem_address_valid_o     = 1'b0;
        mem_write_data_valid_o  = 1'b0;
        mem_address_o           = r_last_addr;
        mem_write_data_o        = r_last_data;
        mem_read_write_select_o = r_last_rw;
        resp_valid_o            = 1'b0;
        resp_is_write_o         = 1'b0;
        case (r_state)
            IDLE: w_next = (!w_empty || w_push) ? ISSUE : IDLE;
            ISSUE: begin
                mem_address_valid_o     = 1'b1;
                mem_write_data_valid_o  = w_head_rw == WRITE;
                mem_address_o           = w_head_addr;
                mem_write_data_o        = w_head_data;
                mem_read_write_select_o = w_head_rw;
                w_next                  = mem_port_ready_i ? WAIT : ISSUE;
            end
            WAIT: w_next = w_done ? RESPOND : WAIT;
            RESPOND: begin
                resp_valid_o    = 1'b1;
                resp_is_write_o = r_inflight_write;
                w_next          = (!w_empty || w_push) ? ISSUE : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_next;
            r_alive <= 1'b1;
        end
    end

    // issued-entry hold, in-flight command and read-result capture
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_last_addr      <= '0;
            r_last_data      <= '0;
            r_last_rw        <= READ;
            r_inflight_write <= READ;
            r_resp_data      <= '0;
        end else begin
            if (r_state == ISSUE) begin
                r_last_addr <= w_head_addr;
                r_last_data <= w_head_data;
                r_last_rw   <= w_head_rw;
            end
            if (w_pop) r_inflight_write <= w_head_rw;
            if (r_state == WAIT && w_done && r_inflight_write == READ) r_resp_data <= mem_read_data_i;
        end
    end
endmodule

// File: tb/tb_memory_request_queue.sv
// tb_memory_request_queue: directed checks of queueing, ordering, backpressure and reset
module tb_memory_request_queue;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int RL = 9;
    localparam int WL = 14;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic [AW-1:0] req_address_i = '0;
    logic [DW-1:0] req_write_data_i = '0;
    logic          req_read_write_select_i = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [DW-1:0] resp_read_data_o;
    logic          resp_is_write_o;
    logic          resp_valid_o;
    logic [AW-1:0] mem_address_o;
    logic          mem_address_valid_o;
    logic [DW-1:0] mem_write_data_o;
    logic          mem_write_data_valid_o;
    logic          mem_read_write_select_o;
    logic [DW-1:0] mem_read_data_i;
    logic          mem_read_data_valid_i;
    logic          mem_write_done_i;
    logic          mem_port_ready_i;
    logic          busy_o;

    int checks = 0;
    int errors = 0;
    int base;

    always #5 clk = ~clk;

    memory_request_queue #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .QUEUE_DEPTH(4)) dut (
        .clk_i                  (clk),
        .reset_i                (reset_i),
        .req_address_i          (req_address_i),
        .req_write_data_i       (req_write_data_i),
        .req_read_write_select_i(req_read_write_select_i),
        .req_valid_i            (req_valid_i),
        .req_ready_o            (req_ready_o),
        .resp_read_data_o       (resp_read_data_o),
        .resp_is_write_o        (resp_is_write_o),
        .resp_valid_o           (resp_valid_o),
        .mem_address_o          (mem_address_o),
        .mem_address_valid_o    (mem_address_valid_o),
        .mem_write_data_o       (mem_write_data_o),
        .mem_write_data_valid_o (mem_write_data_valid_o),
        .mem_read_write_select_o(mem_read_write_select_o),
        .mem_read_data_i        (mem_read_data_i),
        .mem_read_data_valid_i  (mem_read_data_valid_i),
        .mem_write_done_i       (mem_write_done_i),
        .mem_port_ready_i       (mem_port_ready_i),
        .busy_o                 (busy_o)
    );

    // memory model: accepted command busies the port, then completes with registered timing
    logic [DW-1:0] memarr [8];
    logic [4:0]    cnt = '0;
    logic          pend = 1'b0;
    logic          pwr = 1'b0;
    logic          stall = 1'b0;
    logic [AW-1:0] paddr = '0;

    assign mem_port_ready_i      = !stall && cnt == 0;
    assign mem_read_data_valid_i = pend && !pwr && cnt == 0;
    assign mem_write_done_i      = pend && pwr && cnt == 0;
    assign mem_read_data_i       = mem_read_data_valid_i ? memarr[paddr] : '0;

    always @(posedge clk) begin
        if (reset_i) begin
            pend <= 1'b0;
            cnt  <= '0;
            for (int i = 0; i < 8; i++) memarr[i] <= '0;
        end else begin
            if (cnt != 0) cnt <= cnt - 5'd1;
            if (mem_port_ready_i && pend && cnt == 0) pend <= 1'b0;
            if (mem_address_valid_o && mem_port_ready_i) begin
                pend  <= 1'b1;
                pwr   <= mem_read_write_select_o;
                paddr <= mem_address_o;
                cnt   <= mem_read_write_select_o ? 5'(WL + 1) : 5'(RL + 1);
                if (mem_read_write_select_o) memarr[mem_address_o] <= mem_write_data_o;
            end
        end
    end

    // response recorder: {is_write, data} per pulse
    logic [16:0] rq[$];
    always @(negedge clk) if (!reset_i && resp_valid_o) rq.push_back({resp_is_write_o, resp_read_data_o});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        req_valid_i = 1'b1;
        req_read_write_select_i = rw;
        req_address_i = a;
        req_write_data_i = d;
        while (!req_ready_o && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check("push_timeout", 32'(n), 32'd0);
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input int n);
        int k = 0;
        while (rq.size() < n && k < 500) begin
            tick();
            k++;
        end
        check(tag, 32'(rq.size()), 32'(n));
    endtask

    task automatic check_resp(input string tag, input int idx, input logic w, input logic [DW-1:0] d);
        logic [16:0] e;
        e = (idx < rq.size()) ? rq[idx] : 17'h1ffff;
        check({tag, "_is_write"}, 32'(e[16]), 32'(w));
        check({tag, "_data"}, 32'(e[15:0]), 32'(d));
    endtask

    logic [DW-1:0] exp_mem [8];

    initial begin
        exp_mem = '{16'h0000, 16'h0000, 16'hBEEF, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h5A5A};

        // reset state
        repeat (2) tick();
        check("rst_ready", 32'(req_ready_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_addr_valid", 32'(mem_address_valid_o), 32'd0);
        check("rst_addr", 32'(mem_address_o), 32'd0);
        check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        check("rst_resp_data", 32'(resp_read_data_o), 32'd0);
        reset_i = 1'b0;
        tick();
        check("ready_after_rst", 32'(req_ready_o), 32'd1);

        // single read, cycle-exact latency
        req_valid_i = 1'b1;
        req_read_write_select_i = 1'b0;
        req_address_i = 3'd5;
        tick();
        req_valid_i = 1'b0;
        check("s1_c1_addr_valid", 32'(mem_address_valid_o), 32'd1);
        check("s1_c1_addr", 32'(mem_address_o), 32'd5);
        check("s1_c1_wdata_valid", 32'(mem_write_data_valid_o), 32'd0);
        check("s1_c1_select", 32'(mem_read_write_select_o), 32'd0);
        tick();
        check("s1_c2_addr_valid", 32'(mem_address_valid_o), 32'd0);
        check("s1_c2_addr_hold", 32'(mem_address_o), 32'd5);
        check("s1_c2_busy", 32'(busy_o), 32'd1);
        repeat (10) tick();
        check("s1_c12_resp_valid", 32'(resp_valid_o), 32'd0);
        tick();
        check("s1_c13_resp_valid", 32'(resp_valid_o), 32'd1);
        check("s1_c13_is_write", 32'(resp_is_write_o), 32'd0);
        check("s1_c13_data", 32'(resp_read_data_o), 32'd0);
        tick();
        check("s1_c14_resp_valid", 32'(resp_valid_o), 32'd0);
        check("s1_c14_busy", 32'(busy_o), 32'd0);
        check("s1_count", 32'(rq.size()), 32'd1);

        // write then read of the same address
        base = rq.size();
        req_valid_i = 1'b1;
        req_read_write_select_i = 1'b1;
        req_address_i = 3'd2;
        req_write_data_i = 16'hBEEF;
        tick();
        check("s2_issue_addr", 32'(mem_address_o), 32'd2);
        check("s2_issue_wdata_valid", 32'(mem_write_data_valid_o), 32'd1);
        check("s2_issue_wdata", 32'(mem_write_data_o), 32'hBEEF);
        check("s2_issue_select", 32'(mem_read_write_select_o), 32'd1);
        req_read_write_select_i = 1'b0;
        req_write_data_i = 16'h0000;
        tick();
        req_valid_i = 1'b0;
        wait_resp("s2_count", base + 2);
        check_resp("s2_wack", base, 1'b1, 16'h0000);
        check_resp("s2_read", base + 1, 1'b0, 16'hBEEF);
        repeat (3) tick();
        check("s2_idle_busy", 32'(busy_o), 32'd0);

        // fill with memory stalled; fifth push ignored
        base = rq.size();
        stall = 1'b1;
        req_valid_i = 1'b1;
        req_read_write_select_i = 1'b1; req_address_i = 3'd3; req_write_data_i = 16'h1234;
        tick();
        req_read_write_select_i = 1'b0; req_address_i = 3'd3;
        tick();
        req_read_write_select_i = 1'b0; req_address_i = 3'd2;
        tick();
        check("s3_ready_before_4th", 32'(req_ready_o), 32'd1);
        req_read_write_select_i = 1'b1; req_address_i = 3'd7; req_write_data_i = 16'h5A5A;
        tick();
        check("s3_ready_full", 32'(req_ready_o), 32'd0);
        req_read_write_select_i = 1'b0; req_address_i = 3'd7;
        tick();
        check("s3_ready_still_full", 32'(req_ready_o), 32'd0);
        check("s3_stalled_issue", 32'(mem_address_valid_o), 32'd1);
        check("s3_stalled_head", 32'(mem_address_o), 32'd3);
        req_valid_i = 1'b0;
        stall = 1'b0;
        wait_resp("s3_count", base + 4);
        repeat (40) tick();
        check("s3_exact_count", 32'(rq.size()), 32'(base + 4));
        check_resp("s3_r0", base, 1'b1, 16'hBEEF);
        check_resp("s3_r1", base + 1, 1'b0, 16'h1234);
        check_resp("s3_r2", base + 2, 1'b0, 16'hBEEF);
        check_resp("s3_r3", base + 3, 1'b1, 16'hBEEF);

        // push at full while the head pops in the same cycle
        base = rq.size();
        stall = 1'b1;
        req_valid_i = 1'b1;
        req_read_write_select_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_address_i = 3'(i);
            tick();
        end
        check("s4_full", 32'(req_ready_o), 32'd0);
        stall = 1'b0;
        req_address_i = 3'd6;
        tick();
        req_valid_i = 1'b0;
        check("s4_ready_after_pop", 32'(req_ready_o), 32'd1);
        check("s4_wait_state", 32'(mem_address_valid_o), 32'd0);
        wait_resp("s4_count", base + 4);
        repeat (40) tick();
        check("s4_exact_count", 32'(rq.size()), 32'(base + 4));
        for (int i = 0; i < 4; i++) check_resp("s4_resp", base + i, 1'b0, exp_mem[i]);

        // pointer wrap over ten reads
        base = rq.size();
        for (int i = 0; i < 10; i++) push(1'b0, 3'(i % 8), 16'h0000);
        wait_resp("s5_count", base + 10);
        for (int i = 0; i < 10; i++) check_resp("s5_resp", base + i, 1'b0, exp_mem[i % 8]);

        // reset during WAIT discards the transaction
        repeat (3) tick();
        base = rq.size();
        push(1'b0, 3'd7, 16'h0000);
        repeat (4) tick();
        reset_i = 1'b1;
        #1;
        check("s6_busy_in_rst", 32'(busy_o), 32'd0);
        check("s6_ready_in_rst", 32'(req_ready_o), 32'd0);
        check("s6_resp_valid_in_rst", 32'(resp_valid_o), 32'd0);
        check("s6_addr_in_rst", 32'(mem_address_o), 32'd0);
        repeat (2) tick();
        reset_i = 1'b0;
        tick();
        check("s6_ready_after_rst", 32'(req_ready_o), 32'd1);
        repeat (30) tick();
        check("s6_no_resp", 32'(rq.size()), 32'(base));
        push(1'b1, 3'd4, 16'h0C0F);
        push(1'b0, 3'd4, 16'h0000);
        wait_resp("s6_count", base + 2);
        check_resp("s6_wack", base, 1'b1, 16'h0000);
        check_resp("s6_read", base + 1, 1'b0, 16'h0C0F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
